// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter that lets several word producers share one UART
// transmitter. A word from the granted requester is registered and held on
// the transmitter handshake until it is consumed. Priority then moves to the
// requester after the one just served.
//
// Optional feature (compile-time macro UART_TX_ARB_BURST_LOCK_EN):
//   burst lock. A requester that is still valid when its word is consumed
//   keeps the grant for up to max_burst consecutive words before priority
//   rotates. Without the macro there is no lock or counter logic.
//
// Parameters:
//   width      - word width in bits
//   requesters - number of requesters (2..16)
//   max_burst  - words per grant under burst lock (1..255); unused otherwise
//
// Ports:
//   clock      in   single clock; everything is on its rising edge
//   reset      in   synchronous, active-high reset
//   req_valid  in   [requesters]        requester i has a word pending
//   req_data   in   [requesters*width]  word i at bits [i*width +: width]
//   req_ready  out  [requesters]        one-hot accept strobe (IDLE only)
//   tx_valid   out                      word presented to the transmitter
//   tx_data    out  [width]             registered word
//   tx_ready   in                       transmitter can take a word
//   tx_source  out  [$clog2(requesters)] requester index of tx_data
//   busy       out                      a word is held (state SEND)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int width      = 8,
    parameter int requesters = 4,
    parameter int max_burst  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [requesters-1:0]         req_valid,
    input  logic [requesters*width-1:0]   req_data,
    output logic [requesters-1:0]         req_ready,
    output logic                          tx_valid,
    output logic [width-1:0]              tx_data,
    input  logic                          tx_ready,
    output logic [$clog2(requesters)-1:0] tx_source,
    output logic                          busy
);

    localparam int SW = $clog2(requesters);

    // Parameter range guard, evaluated at elaboration only.
    if (requesters < 2 || requesters > 16 || max_burst < 1 || max_burst > 255) begin : g_param_check
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_tx_valid;
    logic [width-1:0] r_tx_data;
    logic [SW-1:0]   r_tx_source;
    logic [SW-1:0]   r_pointer;

    logic [SW-1:0]   w_start;
    logic [SW-1:0]   w_search_idx;
    logic [SW-1:0]   w_grant_idx;
    logic [SW-1:0]   w_src_next;
    logic            w_found;
    logic            w_accept;
    logic            w_handshake;
    logic            w_ptr_adv;

    // (base + off) mod requesters, valid for base, off < requesters.
    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= requesters) begin
            s = s - requesters;
        end
        return s[SW-1:0];
    endfunction

    assign w_src_next  = wrap_add(r_tx_source, 1);
    assign w_handshake = r_tx_valid && tx_ready;

    // Circular search from w_start. Iterating downward lets the nearest
    // valid requester (smallest offset) overwrite any farther one.
    always_comb begin
        w_found      = 1'b0;
        w_search_idx = '0;
        for (int k = requesters - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(w_start, k)]) begin
                w_found      = 1'b1;
                w_search_idx = wrap_add(w_start, k);
            end
        end
    end

`ifdef UART_TX_ARB_BURST_LOCK_EN
    logic       r_lock;
    logic [7:0] r_burst_cnt;
    logic       w_lock_hold;
    logic       w_lock_drop;
    logic       w_keep_lock;

    // While locked, tx_source still names the locked requester.
    assign w_lock_hold = r_lock && req_valid[r_tx_source];
    assign w_lock_drop = r_lock && !req_valid[r_tx_source] && (r_state == IDLE);
    assign w_keep_lock = req_valid[r_tx_source] && (r_burst_cnt < 8'(max_burst));

    // The pointer is frozen during a lock, so a dropped lock must search
    // from just past the locked requester in the same cycle.
    assign w_start     = r_lock ? w_src_next : r_pointer;
    assign w_grant_idx = w_lock_hold ? r_tx_source : w_search_idx;
    assign w_ptr_adv   = w_handshake ? !w_keep_lock : w_lock_drop;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lock      <= 1'b0;
            r_burst_cnt <= 8'd0;
        end else begin
            if (w_accept) begin
                r_burst_cnt <= w_lock_hold ? (r_burst_cnt + 8'd1) : 8'd1;
            end
            if (w_handshake) begin
                r_lock <= w_keep_lock;
            end else if (w_lock_drop) begin
                r_lock <= 1'b0;
            end
        end
    end
`else
    assign w_start     = r_pointer;
    assign w_grant_idx = w_search_idx;
    assign w_ptr_adv   = w_handshake;
`endif

    // FSM next state and accept strobe. req_ready is gated by reset so no
    // word is taken while the block is being reset.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        req_ready    = '0;
        case (r_state)
            IDLE: begin
                if (w_found && !reset) begin
                    req_ready[w_grant_idx] = 1'b1;
                    w_accept               = 1'b1;
                    w_state_next           = SEND;
                end
            end
            SEND: begin
                if (w_handshake) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
            r_tx_source <= '0;
            r_pointer   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_tx_valid  <= 1'b1;
                r_tx_data   <= req_data[int'(w_grant_idx) * width +: width];
                r_tx_source <= w_grant_idx;
            end else if (w_handshake) begin
                r_tx_valid <= 1'b0;
            end
            if (w_ptr_adv) begin
                r_pointer <= w_src_next;
            end
        end
    end

    assign tx_valid  = r_tx_valid;
    assign tx_data   = r_tx_data;
    assign tx_source = r_tx_source;
    assign busy      = (r_state == SEND);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int MB = 3;
    localparam int SW = 2;
    localparam int WORDS_PER_REQ = 20;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [W-1:0]   tx_data;
    logic           tx_ready;
    logic [SW-1:0]  tx_source;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] rq [N][$];

    always #5 clock = ~clock;

    uart_tx_arbiter #(.width(W), .requesters(N), .max_burst(MB)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .tx_source(tx_source), .busy(busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic sample_edge();
        @(negedge clock);
    endtask

    task automatic set_word(input int i, input logic [W-1:0] d);
        req_data[i*W +: W] = d;
    endtask

    task automatic apply_reset();
        drive_edge();
        reset = 1'b1; req_valid = '0; tx_ready = 1'b0;
        drive_edge();
        drive_edge();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drive_edge();
        reset = 1'b1; req_valid = '1; tx_ready = 1'b1;
        for (int i = 0; i < N; i++) set_word(i, W'($urandom));
        drive_edge();
        drive_edge();
        sample_edge();
        n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready actual=%b required=0000", req_ready); end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid actual=%b required=0", tx_valid); end
        n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data actual=%h required=00", tx_data); end
        n_tests++; if (tx_source !== 2'd0) begin n_fail++; $display("FAIL reset_tx_source actual=%0d required=0", tx_source); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%b required=0", busy); end
        drive_edge();
        reset = 1'b0; req_valid = '0; tx_ready = 1'b0;
    endtask

    task automatic test_basic();
        req_valid = 4'b0101; set_word(0, 8'h11); set_word(2, 8'h33); tx_ready = 1'b1;
        sample_edge();
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL basic_ready0 actual=%b required=0001", req_ready); end
        drive_edge(); req_valid = 4'b0100;
        sample_edge();
        n_tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h11 || tx_source !== 2'd0) begin n_fail++; $display("FAIL basic_word0 actual=%b/%h/%0d required=1/11/0", tx_valid, tx_data, tx_source); end
        n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL basic_ready_send actual=%b required=0000", req_ready); end
        drive_edge();
        sample_edge();
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle0 actual=%b required=0", tx_valid); end
        n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL basic_ready2 actual=%b required=0100", req_ready); end
        drive_edge(); req_valid = 4'b0000;
        sample_edge();
        n_tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h33 || tx_source !== 2'd2) begin n_fail++; $display("FAIL basic_word2 actual=%b/%h/%0d required=1/33/2", tx_valid, tx_data, tx_source); end
        drive_edge();
        sample_edge();
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle2 actual=%b required=0", tx_valid); end
        drive_edge();
    endtask

    task automatic test_round_robin();
        int got;
        int exp_s;
        got = 0;
        apply_reset();
        req_valid = '1; tx_ready = 1'b1;
        for (int i = 0; i < N; i++) set_word(i, W'(8'hC0 + i));
        for (int c = 0; c < 40 && got < 8; c++) begin
            sample_edge();
            if (tx_valid && tx_ready) begin
`ifdef UART_TX_ARB_BURST_LOCK_EN
                exp_s = (got / MB) % N;
`else
                exp_s = got % N;
`endif
                n_tests++; if (tx_source !== SW'(exp_s) || tx_data !== W'(8'hC0 + exp_s)) begin n_fail++; $display("FAIL rr_word%0d actual=%0d/%h required=%0d/%h", got, tx_source, tx_data, exp_s, 8'hC0 + exp_s); end
                got++;
            end
            drive_edge();
        end
        n_tests++; if (got != 8) begin n_fail++; $display("FAIL rr_count actual=%0d required=8", got); end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        req_valid = 4'b0010; set_word(1, 8'hA5); tx_ready = 1'b0;
        sample_edge();
        n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_accept actual=%b required=0010", req_ready); end
        drive_edge(); set_word(1, 8'h5A);
        for (int c = 0; c < 20; c++) begin
            sample_edge();
            n_tests++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d actual=%b/%h/%b required=1/a5/1", c, tx_valid, tx_data, busy); end
            n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_noready%0d actual=%b required=0000", c, req_ready); end
            drive_edge();
        end
        tx_ready = 1'b1;
        sample_edge();
        n_tests++; if (req_ready !== 4'b0000 || tx_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release actual=%b/%b required=0000/1", req_ready, tx_valid); end
        drive_edge();
        sample_edge();
        n_tests++; if (req_ready !== 4'b0010 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL bp_next_ready actual=%b/%b required=0010/0", req_ready, tx_valid); end
        drive_edge(); req_valid = '0;
        sample_edge();
        n_tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h5A) begin n_fail++; $display("FAIL bp_next_word actual=%b/%h required=1/5a", tx_valid, tx_data); end
        drive_edge();
    endtask

    task automatic test_reset_in_send();
        bit seen;
        seen = 1'b0;
        apply_reset();
        req_valid = 4'b0010; set_word(1, 8'h21); tx_ready = 1'b1;
        sample_edge();
        n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rs_first actual=%b required=0010", req_ready); end
        drive_edge(); req_valid = '0;
        sample_edge();
        drive_edge();
        req_valid = 4'b0100; set_word(2, 8'h7E); tx_ready = 1'b0;
        sample_edge();
        n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rs_accept actual=%b required=0100", req_ready); end
        drive_edge(); req_valid = '0;
        sample_edge();
        n_tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h7E || tx_source !== 2'd2) begin n_fail++; $display("FAIL rs_held actual=%b/%h/%0d required=1/7e/2", tx_valid, tx_data, tx_source); end
        drive_edge();
        sample_edge();
        drive_edge(); reset = 1'b1;
        sample_edge();
        drive_edge();
        reset = 1'b0; req_valid = '1; tx_ready = 1'b1;
        for (int i = 0; i < N; i++) set_word(i, W'(8'h40 + i));
        sample_edge();
        n_tests++; if (tx_valid !== 1'b0 || tx_source !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rs_cleared actual=%b/%0d/%b required=0/0/0", tx_valid, tx_source, busy); end
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rs_pointer actual=%b required=0001", req_ready); end
        for (int c = 0; c < 12; c++) begin
            drive_edge();
            sample_edge();
            if (tx_valid && tx_ready && tx_data === 8'h7E) seen = 1'b1;
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL rs_discard actual=sent required=discarded"); end
        drive_edge(); req_valid = '0;
    endtask

    task automatic test_random();
        int ptr, msrc, mcnt, exp_idx, delivered;
        bit mbusy, mlock, lockgrant;
        logic [W-1:0] mdat;
        logic [N-1:0] exp_rdy;
        ptr = 0; msrc = 0; mcnt = 0; delivered = 0;
        mbusy = 1'b0; mlock = 1'b0; mdat = '0;
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            for (int j = 0; j < WORDS_PER_REQ; j++) rq[i].push_back(W'($urandom));
        end
        apply_reset();
        for (int c = 0; c < 4000 && delivered < N * WORDS_PER_REQ; c++) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = (rq[i].size() > 0) && ($urandom_range(0, 3) != 0);
                set_word(i, (rq[i].size() > 0) ? rq[i][0] : W'($urandom));
            end
            tx_ready = ($urandom_range(0, 2) != 0);
            sample_edge();
            exp_idx = -1; exp_rdy = '0; lockgrant = 1'b0;
            if (!mbusy) begin
`ifdef UART_TX_ARB_BURST_LOCK_EN
                if (mlock && req_valid[msrc]) begin
                    exp_idx = msrc; lockgrant = 1'b1;
                end else if (mlock) begin
                    mlock = 1'b0; ptr = (msrc + 1) % N;
                end
`endif
                if (exp_idx < 0) begin
                    for (int k = 0; k < N; k++) begin
                        if (exp_idx < 0 && req_valid[(ptr + k) % N]) exp_idx = (ptr + k) % N;
                    end
                end
                if (exp_idx >= 0) exp_rdy[exp_idx] = 1'b1;
            end
            n_tests++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready c%0d actual=%b required=%b", c, req_ready, exp_rdy); end
            n_tests++; if (tx_valid !== mbusy) begin n_fail++; $display("FAIL rnd_valid c%0d actual=%b required=%b", c, tx_valid, mbusy); end
            if (mbusy) begin
                n_tests++; if (tx_data !== mdat || tx_source !== SW'(msrc)) begin n_fail++; $display("FAIL rnd_word c%0d actual=%h/%0d required=%h/%0d", c, tx_data, tx_source, mdat, msrc); end
                if (tx_ready) begin
`ifdef UART_TX_ARB_BURST_LOCK_EN
                    if (req_valid[msrc] && mcnt < MB) mlock = 1'b1;
                    else begin mlock = 1'b0; ptr = (msrc + 1) % N; end
`else
                    ptr = (msrc + 1) % N;
`endif
                    mbusy = 1'b0;
                    delivered++;
                end
            end else if (exp_idx >= 0) begin
                mcnt  = lockgrant ? mcnt + 1 : 1;
                mbusy = 1'b1;
                msrc  = exp_idx;
                mdat  = rq[exp_idx].pop_front();
            end
            drive_edge();
        end
        n_tests++; if (delivered != N * WORDS_PER_REQ) begin n_fail++; $display("FAIL rnd_delivered actual=%0d required=%0d", delivered, N * WORDS_PER_REQ); end
        req_valid = '0; tx_ready = 1'b0;
    endtask

`ifdef UART_TX_ARB_BURST_LOCK_EN
    task automatic test_burst();
        int exp_b [7];
        int got;
        exp_b = '{2, 2, 2, 3, 3, 3, 2};
        got = 0;
        apply_reset();
        req_valid = 4'b1100; set_word(2, 8'h82); set_word(3, 8'h83); tx_ready = 1'b1;
        for (int c = 0; c < 40 && got < 7; c++) begin
            sample_edge();
            if (tx_valid && tx_ready) begin
                n_tests++; if (tx_source !== SW'(exp_b[got])) begin n_fail++; $display("FAIL burst_word%0d actual=%0d required=%0d", got, tx_source, exp_b[got]); end
                got++;
            end
            drive_edge();
        end
        n_tests++; if (got != 7) begin n_fail++; $display("FAIL burst_count actual=%0d required=7", got); end
        req_valid = '0;
    endtask
`endif

    task automatic test_stream();
        int w, nout, last_acc;
        bit acc;
        w = 0; nout = 0; last_acc = -1;
        apply_reset();
        req_valid = 4'b1000; set_word(3, 8'h00); tx_ready = 1'b1;
        for (int c = 0; c < 700 && nout < 256; c++) begin
            sample_edge();
            acc = 1'b0;
            if (req_ready[3] && req_valid[3]) begin
                if (last_acc >= 0) begin
                    n_tests++; if (c - last_acc != 2) begin n_fail++; $display("FAIL stream_gap w%0d actual=%0d required=2", w, c - last_acc); end
                end
                last_acc = c; acc = 1'b1;
            end
            if (tx_valid && tx_ready) begin
                n_tests++; if (tx_data !== 8'(nout)) begin n_fail++; $display("FAIL stream_data actual=%h required=%h", tx_data, 8'(nout)); end
                nout++;
            end
            drive_edge();
            if (acc) begin
                w++;
                if (w < 256) set_word(3, 8'(w));
                else req_valid = '0;
            end
        end
        n_tests++; if (nout != 256) begin n_fail++; $display("FAIL stream_count actual=%0d required=256", nout); end
        req_valid = '0;
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_data = '0; tx_ready = 1'b0;
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_reset_in_send();
        test_random();
`ifdef UART_TX_ARB_BURST_LOCK_EN
        test_burst();
`endif
        test_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
